rom_port_arbiter: RTL and testbench

- Shares the single combinational instruction-ROM read port between two requesters:
  - instruction fetch (IF);
  - data-side loads from the text segment (LD), e.g. constant tables.
- Registers the ROM address, captures the ROM word one cycle later and returns it to the granted requester.
- Checks range and alignment, and prevents LD starvation under continuous fetch.
- Sits between the fetch stage / memory stage and the ROM (rom8x1024_sim in simulation).

---
 rtl/rom_port_arbiter_pkg.sv | 29 ++
 rtl/rom_port_arbiter_addr_check.sv | 16 +
 rtl/rom_port_arbiter.sv | 132 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for ROM port access: default window, requester
// encoding and the address window check also used by the RAM-side decoder.
package rom_port_arbiter_pkg;

    localparam logic [31:0] ROM_BASE_DEFAULT  = 32'h0040_0000;
    localparam int          ROM_BYTES_DEFAULT = 4096;
    localparam int          WAIT_MAX_DEFAULT  = 4;

    // Which requester owns an in-flight ROM access.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LD = 1'b1
    } req_who_e;

    // Word aligned and inside [base, base+bytes). The difference is taken in
    // 33 bits so an address below base can never wrap into the window.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] bytes
    );
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, base};
        return (addr[1:0] == 2'b00) &&
               ({1'b0, addr} >= {1'b0, base}) &&
               (diff < bytes);
    endfunction

endpackage

// File: rtl/rom_port_arbiter_addr_check.sv
// Combinational window/alignment check and byte offset for one address.
module rom_addr_check
    import rom_port_arbiter_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = ROM_BASE_DEFAULT,
    parameter int          ROM_BYTES = ROM_BYTES_DEFAULT
) (
    input  logic [31:0] i_addr,
    output logic        o_ok,
    output logic [11:0] o_offset
);

    assign o_ok     = addr_in_window(i_addr, ROM_BASE, 33'(ROM_BYTES));
    assign o_offset = 12'(i_addr - ROM_BASE);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter for the single combinational instruction-ROM port.
// IF normally wins; LD is forced after WAIT_MAX consecutive losses.
// Grant cycle registers the ROM address, the next cycle captures the word.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = ROM_BASE_DEFAULT,
    parameter int          ROM_BYTES = ROM_BYTES_DEFAULT,
    parameter int          WAIT_MAX  = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        ld_err,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic             w_starve;
    logic             w_if_gnt;
    logic             w_ld_gnt;
    logic             w_any_gnt;
    logic [31:0]      w_sel_addr;
    logic             w_ok;
    logic [11:0]      w_offset;
    logic [31:0]      w_rdata_p1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_vld_p1;
    req_who_e         r_who_p1;
    logic             r_err_p1;
    logic [11:0]      r_rom_addr;

    logic             r_if_rvalid_p2;
    logic [31:0]      r_if_rdata_p2;
    logic             r_if_err_p2;
    logic             r_ld_rvalid_p2;
    logic [31:0]      r_ld_rdata_p2;
    logic             r_ld_err_p2;

    // Arbitration: IF priority unless LD has lost WAIT_MAX cycles in a row.
    assign w_starve   = (r_wait_cnt == CNT_W'(WAIT_MAX));
    assign w_ld_gnt   = ~rst & ld_req & (~if_req | w_starve);
    assign w_if_gnt   = ~rst & if_req & ~w_ld_gnt;
    assign w_any_gnt  = w_if_gnt | w_ld_gnt;
    assign w_sel_addr = w_ld_gnt ? ld_addr : if_addr;

    rom_addr_check #(
        .ROM_BASE  (ROM_BASE),
        .ROM_BYTES (ROM_BYTES)
    ) u_addr_check (
        .i_addr   (w_sel_addr),
        .o_ok     (w_ok),
        .o_offset (w_offset)
    );

    // Count consecutive cycles a pending LD loses to IF, saturating at WAIT_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_ld_gnt || !ld_req) begin
            r_wait_cnt <= '0;
        end else if (w_if_gnt && !w_starve) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Stage p1: latch the granted access; a bad address leaves rom_addr alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_who_p1   <= REQ_IF;
            r_err_p1   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_vld_p1 <= w_any_gnt;
            r_who_p1 <= w_ld_gnt ? REQ_LD : REQ_IF;
            r_err_p1 <= ~w_ok;
            if (w_any_gnt && w_ok) begin
                r_rom_addr <= w_offset;
            end
        end
    end

    assign w_rdata_p1 = r_err_p1 ? 32'h0 : rom_data;

    // Stage p2: route the ROM word to its owner; the other side's data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rvalid_p2 <= 1'b0;
            r_if_rdata_p2  <= '0;
            r_if_err_p2    <= 1'b0;
            r_ld_rvalid_p2 <= 1'b0;
            r_ld_rdata_p2  <= '0;
            r_ld_err_p2    <= 1'b0;
        end else begin
            r_if_rvalid_p2 <= r_vld_p1 && (r_who_p1 == REQ_IF);
            r_ld_rvalid_p2 <= r_vld_p1 && (r_who_p1 == REQ_LD);
            if (r_vld_p1 && (r_who_p1 == REQ_IF)) begin
                r_if_rdata_p2 <= w_rdata_p1;
                r_if_err_p2   <= r_err_p1;
            end
            if (r_vld_p1 && (r_who_p1 == REQ_LD)) begin
                r_ld_rdata_p2 <= w_rdata_p1;
                r_ld_err_p2   <= r_err_p1;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign rom_addr  = r_rom_addr;
    assign if_rvalid = r_if_rvalid_p2;
    assign if_rdata  = r_if_rdata_p2;
    assign if_err    = r_if_err_p2;
    assign ld_rvalid = r_ld_rvalid_p2;
    assign ld_rdata  = r_ld_rdata_p2;
    assign ld_err    = r_ld_err_p2;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: a ROM array, a transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_rom_port_arbiter;

    localparam logic [31:0] BASE     = 32'h0040_0000;
    localparam int          BYTES    = 4096;
    localparam int          WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ld_gnt, ld_rvalid, ld_err;
    logic [31:0] ld_rdata;
    logic [11:0] rom_addr;
    logic [31:0] rom_data;

    logic [31:0] rom_mem [1024];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(
        .ROM_BASE  (BASE),
        .ROM_BYTES (BYTES),
        .WAIT_MAX  (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .ld_err    (ld_err),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    assign rom_data = rom_mem[rom_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom_mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
        end
        rom_mem[8]  = 32'h27bd_fff8;
        rom_mem[9]  = 32'hafbe_0000;
        rom_mem[10] = 32'h03a0_f021;
        rom_mem[11] = 32'h2402_0300;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          is_ld;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    int          m_cyc = 0;
    int          m_wait = 0;
    logic [11:0] m_rom_addr = '0;
    logic [31:0] m_if_data = '0, m_ld_data = '0;
    logic        m_if_err = 1'b0, m_ld_err = 1'b0;

    function automatic bit in_rom(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a[1:0] == 2'b00) && (la >= longint'(BASE)) &&
               (la < longint'(BASE) + longint'(BYTES));
    endfunction

    always @(negedge clk) begin : model
        resp_t       e;
        bit          e_if_rv, e_ld_rv, e_ldg, e_ifg, ok;
        logic [31:0] a, off;
        m_cyc++;
        e_if_rv = 1'b0;
        e_ld_rv = 1'b0;
        if (q.size() > 0 && q[0].due == m_cyc) begin
            e = q.pop_front();
            if (e.is_ld) begin
                e_ld_rv = 1'b1; m_ld_data = e.data; m_ld_err = e.err;
            end else begin
                e_if_rv = 1'b1; m_if_data = e.data; m_if_err = e.err;
            end
        end
        chk("m_if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        chk("m_ld_rvalid", 32'(ld_rvalid), 32'(e_ld_rv));
        chk("m_if_rdata",  if_rdata, m_if_data);
        chk("m_ld_rdata",  ld_rdata, m_ld_data);
        chk("m_if_err",    32'(if_err), 32'(m_if_err));
        chk("m_ld_err",    32'(ld_err), 32'(m_ld_err));
        chk("m_rom_addr",  32'(rom_addr), 32'(m_rom_addr));

        e_ldg = !rst && ld_req && (!if_req || m_wait == WAIT_MAX);
        e_ifg = !rst && if_req && !e_ldg;
        chk("m_if_gnt", 32'(if_gnt), 32'(e_ifg));
        chk("m_ld_gnt", 32'(ld_gnt), 32'(e_ldg));

        if (rst) begin
            q.delete();
            m_wait = 0;
            m_rom_addr = '0;
            m_if_data = '0; m_ld_data = '0;
            m_if_err = 1'b0; m_ld_err = 1'b0;
        end else begin
            if (e_ldg || e_ifg) begin
                a   = e_ldg ? ld_addr : if_addr;
                ok  = in_rom(a);
                off = a - BASE;
                e.due   = m_cyc + 2;
                e.is_ld = e_ldg;
                e.err   = !ok;
                e.data  = ok ? rom_mem[off[11:2]] : 32'h0;
                q.push_back(e);
                if (ok) m_rom_addr = off[11:0];
            end
            if (e_ldg || !ld_req) m_wait = 0;
            else if (e_ifg && m_wait < WAIT_MAX) m_wait++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia,
                          input logic lr, input logic [31:0] la);
        if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
    endtask

    // Hold both requests until LD wins; count how many IF grants came first.
    task automatic starve_round(input string nm);
        int n_if;
        bit got;
        n_if = 0;
        got  = 1'b0;
        set_in(1'b1, 32'h0040_0020, 1'b1, 32'h0040_002c);
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (ld_rvalid) chk({nm, "_ld_rdata"}, ld_rdata, 32'h2402_0300);
            if (ld_gnt) begin
                got = 1'b1;
                chk({nm, "_if_gnt_off"}, 32'(if_gnt), 32'd0);
            end else if (if_gnt) begin
                n_if++;
            end
            tick;
        end
        chk({nm, "_ld_granted"}, 32'(got), 32'd1);
        chk({nm, "_if_wins"}, 32'(n_if), 32'd4);
    endtask

    logic [31:0] err_addr [4];
    logic        err_exp  [4];

    initial begin
        err_addr[0] = 32'h0040_1000; err_exp[0] = 1'b1;
        err_addr[1] = 32'h003f_fffc; err_exp[1] = 1'b1;
        err_addr[2] = 32'h0040_0ffc; err_exp[2] = 1'b0;
        err_addr[3] = 32'hffff_fffc; err_exp[3] = 1'b1;

        // Reset with both requesting: no grants, outputs at reset values.
        set_in(1'b1, 32'h0040_0020, 1'b1, 32'h0040_002c);
        tick;
        tick;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, '0);
        tick;

        // Single fetch.
        set_in(1'b1, 32'h0040_0020, 1'b0, '0);
        #1 chk("single_if_gnt", 32'(if_gnt), 32'd1);
        tick;
        set_in(1'b0, '0, 1'b0, '0);
        chk("single_rom_addr", 32'(rom_addr), 32'h020);
        chk("single_no_rvalid_yet", 32'(if_rvalid), 32'd0);
        tick;
        chk("single_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("single_if_rdata", if_rdata, 32'h27bd_fff8);
        chk("single_if_err", 32'(if_err), 32'd0);
        tick;

        // Back-to-back fetches.
        set_in(1'b1, 32'h0040_0024, 1'b0, '0);
        tick;
        set_in(1'b1, 32'h0040_0028, 1'b0, '0);
        tick;
        set_in(1'b0, '0, 1'b0, '0);
        chk("b2b_rvalid0", 32'(if_rvalid), 32'd1);
        chk("b2b_rdata0", if_rdata, 32'hafbe_0000);
        tick;
        chk("b2b_rvalid1", 32'(if_rvalid), 32'd1);
        chk("b2b_rdata1", if_rdata, 32'h03a0_f021);
        tick;
        chk("b2b_rvalid_end", 32'(if_rvalid), 32'd0);
        chk("b2b_rdata_hold", if_rdata, 32'h03a0_f021);

        // Starvation twice in a row: the counter restarts after each LD grant.
        starve_round("starve1");
        starve_round("starve2");
        set_in(1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 4; k++) tick;

        // Misaligned load: error response, rom_addr keeps the last good offset.
        set_in(1'b0, '0, 1'b1, 32'h0040_0031);
        #1 chk("mis_ld_gnt", 32'(ld_gnt), 32'd1);
        tick;
        set_in(1'b0, '0, 1'b0, '0);
        chk("mis_rom_addr", 32'(rom_addr), 32'h02c);
        tick;
        chk("mis_ld_rvalid", 32'(ld_rvalid), 32'd1);
        chk("mis_ld_err", 32'(ld_err), 32'd1);
        chk("mis_ld_rdata", ld_rdata, 32'd0);
        tick;

        // Window edges for fetch.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, err_addr[k], 1'b0, '0);
            tick;
            set_in(1'b0, '0, 1'b0, '0);
            tick;
            chk("win_if_rvalid", 32'(if_rvalid), 32'd1);
            chk("win_if_err", 32'(if_err), 32'(err_exp[k]));
            if (err_exp[k]) chk("win_if_rdata", if_rdata, 32'd0);
            else            chk("win_if_rdata", if_rdata, rom_mem[1023]);
            tick;
        end

        // Reset right after a grant: response dropped, counter cleared.
        set_in(1'b1, 32'h0040_0024, 1'b1, 32'h0040_002c);
        #1 chk("rmid_if_gnt", 32'(if_gnt), 32'd1);
        tick;
        rst = 1'b1;
        #1;
        chk("rmid_gnt_blocked", 32'({if_gnt, ld_gnt}), 32'd0);
        tick;
        rst = 1'b0;
        chk("rmid_no_rvalid", 32'(if_rvalid), 32'd0);
        chk("rmid_rom_addr", 32'(rom_addr), 32'd0);
        chk("rmid_if_rdata", if_rdata, 32'd0);
        starve_round("rmid_starve");
        set_in(1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 4; k++) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
